usb_fs_out_ep_buf: RTL and testbench

OUT endpoint receive buffer that sits directly upstream of the OUT-endpoint arbiter. When the protocol engine holds a completed OUT or SETUP data packet for this endpoint, the block raises `out_ep_req`. After grant, it drains the packet byte-by-byte into a local tagged FIFO. The application then reads the bytes with packet-boundary and SETUP markers.

---
 rtl/usb_fs_out_ep_buf_if.sv | 43 ++++
 rtl/usb_fs_out_ep_buf.sv | 131 +++++++++++++
 tb/tb_usb_fs_out_ep_buf.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/usb_fs_out_ep_buf_if.sv
// usb_fs_out_ep_buf_if
//   Bundles the two sides of the OUT endpoint receive buffer:
//   - protocol-engine / arbiter side: out_ep_data_avail, out_ep_setup,
//     out_ep_pkt_len, out_ep_req, out_ep_grant, out_ep_data_get,
//     out_ep_data, out_ep_done
//   - application side: app_rd, app_data, app_last, app_setup,
//     app_empty, app_level, app_zlp
//   master: the environment (PE, arbiter, application)
//   slave : the buffer itself
interface usb_fs_out_ep_buf_if #(
  parameter int DEPTH = 128,
  parameter int LEN_W = 7
);
  logic                     out_ep_data_avail;
  logic                     out_ep_setup;
  logic [LEN_W-1:0]         out_ep_pkt_len;
  logic                     out_ep_req;
  logic                     out_ep_grant;
  logic                     out_ep_data_get;
  logic [7:0]               out_ep_data;
  logic                     out_ep_done;
  logic                     app_rd;
  logic [7:0]               app_data;
  logic                     app_last;
  logic                     app_setup;
  logic                     app_empty;
  logic [$clog2(DEPTH):0]   app_level;
  logic                     app_zlp;

  modport master (
    output out_ep_data_avail, out_ep_setup, out_ep_pkt_len, out_ep_grant,
           out_ep_data, app_rd,
    input  out_ep_req, out_ep_data_get, out_ep_done, app_data, app_last,
           app_setup, app_empty, app_level, app_zlp
  );

  modport slave (
    input  out_ep_data_avail, out_ep_setup, out_ep_pkt_len, out_ep_grant,
           out_ep_data, app_rd,
    output out_ep_req, out_ep_data_get, out_ep_done, app_data, app_last,
           app_setup, app_empty, app_level, app_zlp
  );
endinterface

// File: rtl/usb_fs_out_ep_buf.sv
// usb_fs_out_ep_buf
//   Full-speed USB OUT endpoint receive buffer. Requests the OUT-endpoint
//   arbiter when the PE holds a finished OUT/SETUP packet, drains it byte by
//   byte into a tagged FIFO ({setup, last, data}) and lets the application
//   pop bytes with packet-boundary and SETUP markers.
// Ports:
//   clk   : sole clock, rising edge
//   reset : asynchronous, active-high
//   bus   : usb_fs_out_ep_buf_if.slave (PE/arbiter and application signals)
module usb_fs_out_ep_buf #(
  parameter int DEPTH = 128,
  parameter int LEN_W = 7
) (
  input  logic                  clk,
  input  logic                  reset,
  usb_fs_out_ep_buf_if.slave    bus
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, XFER, FIN} state_t;

  state_t           state, next_state;
  logic [LEN_W-1:0] len_l, issued, written;
  logic             setup_l;
  logic             first_req;
  logic             pending;
  logic             done_q, zlp_q;
  logic [AW:0]      wptr, rptr;
  logic [AW:0]      level;
  logic [9:0]       mem [DEPTH];

  logic             space_ok, last_byte, flush, get, pop;

  assign level     = wptr - rptr;
  // A SETUP packet flushes the FIFO first, so it never waits for space.
  assign space_ok  = setup_l || ((32'(DEPTH) - 32'(level)) >= 32'(len_l));
  assign last_byte = (written + LEN_W'(1)) == len_l;
  assign flush     = (state == REQ) && first_req && setup_l;
  // Flush wins over a same-cycle application pop.
  assign pop       = bus.app_rd && (level != '0) && !flush;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: if (bus.out_ep_data_avail) next_state = REQ;
      REQ:  if (bus.out_ep_grant && space_ok)
              next_state = (len_l == '0) ? FIN : XFER;
      XFER: if (pending && last_byte) next_state = FIN;
      FIN:  if (!bus.out_ep_data_avail) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    bus.out_ep_req  = (state == REQ) || (state == XFER);
    get             = (state == XFER) && bus.out_ep_grant && (issued < len_l);
    bus.out_ep_data_get = get;
    bus.out_ep_done = done_q;
    bus.app_zlp     = zlp_q;
  end

  assign bus.app_level = level;
  assign bus.app_empty = (level == '0);

  // Transfer bookkeeping and FIFO pointers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      len_l         <= '0;
      setup_l       <= 1'b0;
      first_req     <= 1'b0;
      issued        <= '0;
      written       <= '0;
      pending       <= 1'b0;
      done_q        <= 1'b0;
      zlp_q         <= 1'b0;
      wptr          <= '0;
      rptr          <= '0;
      bus.app_data  <= '0;
      bus.app_last  <= 1'b0;
      bus.app_setup <= 1'b0;
    end else begin
      if ((state == IDLE) && bus.out_ep_data_avail) begin
        len_l   <= bus.out_ep_pkt_len;
        setup_l <= bus.out_ep_setup;
      end
      first_req <= (state != REQ) && (next_state == REQ);

      if (state == REQ) begin
        issued  <= '0;
        written <= '0;
      end else if (get) begin
        issued <= issued + LEN_W'(1);
      end

      // The byte requested in one cycle arrives in the next, even if grant
      // has dropped meanwhile.
      pending <= get;
      if (pending) begin
        written <= written + LEN_W'(1);
        wptr    <= wptr + 1'b1;
      end

      done_q <= (state != FIN) && (next_state == FIN);
      zlp_q  <= (state == REQ) && (next_state == FIN);

      if (flush) begin
        rptr <= wptr;
      end else if (pop) begin
        rptr          <= rptr + 1'b1;
        bus.app_data  <= mem[rptr[AW-1:0]][7:0];
        bus.app_last  <= mem[rptr[AW-1:0]][8];
        bus.app_setup <= mem[rptr[AW-1:0]][9];
      end
    end
  end

  // FIFO storage
  always_ff @(posedge clk) begin
    if (pending) mem[wptr[AW-1:0]] <= {setup_l, last_byte, bus.out_ep_data};
  end

endmodule

// File: tb/tb_usb_fs_out_ep_buf.sv
module tb_usb_fs_out_ep_buf;

  localparam int DEPTH = 128;
  localparam int LEN_W = 7;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  usb_fs_out_ep_buf_if #(.DEPTH(DEPTH), .LEN_W(LEN_W)) bus ();

  usb_fs_out_ep_buf #(.DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: ordered list of {setup, last, data} entries the
  // application should see.
  logic [9:0] model [$];
  logic [7:0] pe_pkt [64];

  // Event counters kept by monitors
  int get_cnt = 0, bad_get = 0, done_cnt = 0, zlp_cnt = 0;
  logic pe_get_q = 1'b0;
  int pe_idx = 0;

  initial forever begin
    @(negedge clk);
    pe_get_q = bus.out_ep_data_get;
    if (bus.out_ep_data_get) get_cnt++;
    if (bus.out_ep_data_get && !bus.out_ep_grant) bad_get++;
    if (bus.out_ep_done) done_cnt++;
    if (bus.app_zlp) zlp_cnt++;
  end

  // Protocol-engine model: byte valid the cycle after a get.
  initial forever begin
    @(posedge clk);
    #2;
    if (reset || !bus.out_ep_data_avail) pe_idx = 0;
    else if (pe_get_q && pe_idx < 64) begin
      bus.out_ep_data = pe_pkt[pe_idx];
      pe_idx++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic fill_pkt(input int len, input bit rnd);
    for (int i = 0; i < len; i++) pe_pkt[i] = rnd ? 8'($urandom) : 8'(i);
  endtask

  task automatic model_push(input bit s, input int len);
    if (s) model.delete();
    for (int i = 0; i < len; i++) model.push_back({s, (i == len - 1), pe_pkt[i]});
  endtask

  task automatic offer(input bit s, input int len, input bit rnd);
    fill_pkt(len, rnd);
    model_push(s, len);
    bus.out_ep_setup      = s;
    bus.out_ep_pkt_len    = LEN_W'(len);
    bus.out_ep_data_avail = 1'b1;
  endtask

  task automatic wait_done(input string tag, input int budget, input bit rnd_grant, output int k);
    k = -1;
    for (int c = 1; c <= budget; c++) begin
      if (rnd_grant) bus.out_ep_grant = ($urandom_range(0, 3) != 0);
      tick();
      if (bus.out_ep_done === 1'b1) begin
        k = c;
        break;
      end
    end
    bus.out_ep_grant = 1'b1;
    chk({tag, "_done_seen"}, 32'(k >= 0), 32'd1);
  endtask

  task automatic end_pkt(input string tag);
    bus.out_ep_data_avail = 1'b0;
    tick();
    tick();
    chk({tag, "_req_low"}, 32'(bus.out_ep_req), 32'd0);
  endtask

  task automatic pop_chk(input string tag);
    logic [9:0] e;
    if (model.size() == 0) return;
    e = model.pop_front();
    bus.app_rd = 1'b1;
    tick();
    bus.app_rd = 1'b0;
    chk(tag, 32'({bus.app_setup, bus.app_last, bus.app_data}), 32'(e));
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req"},   32'(bus.out_ep_req), 0);
    chk({tag, "_get"},   32'(bus.out_ep_data_get), 0);
    chk({tag, "_done"},  32'(bus.out_ep_done), 0);
    chk({tag, "_data"},  32'(bus.app_data), 0);
    chk({tag, "_last"},  32'(bus.app_last), 0);
    chk({tag, "_setup"}, 32'(bus.app_setup), 0);
    chk({tag, "_empty"}, 32'(bus.app_empty), 1);
    chk({tag, "_level"}, 32'(bus.app_level), 0);
    chk({tag, "_zlp"},   32'(bus.app_zlp), 0);
  endtask

  int k, g0, d0, z0, n, len;
  bit s;
  logic [31:0] mask;

  initial begin
    reset = 1'b1;
    bus.out_ep_data_avail = 1'b0;
    bus.out_ep_setup      = 1'b0;
    bus.out_ep_pkt_len    = '0;
    bus.out_ep_grant      = 1'b0;
    bus.app_rd            = 1'b0;
    repeat (3) tick();
    chk_reset_outputs("rst");
    reset = 1'b0;
    tick();

    // 8-byte OUT with grant held
    chk("t1_idle_req", 32'(bus.out_ep_req), 0);
    offer(1'b0, 8, 1'b0);
    bus.out_ep_grant = 1'b1;
    tick();
    chk("t1_req_rise", 32'(bus.out_ep_req), 1);
    mask = '0;
    k = -1;
    for (int c = 1; c <= 20; c++) begin
      tick();
      mask[c] = bus.out_ep_data_get;
      if (bus.out_ep_done === 1'b1) begin
        k = c;
        break;
      end
    end
    chk("t1_get_mask", mask, 32'h1FE);
    chk("t1_done_cycle", 32'(k), 32'd10);
    end_pkt("t1");
    chk("t1_level", 32'(bus.app_level), 8);
    chk("t1_empty0", 32'(bus.app_empty), 0);
    repeat (8) pop_chk("t1_pop");
    chk("t1_empty1", 32'(bus.app_empty), 1);

    // Grant drops for 3 cycles after the 2nd get of a 4-byte packet
    d0 = done_cnt; g0 = get_cnt;
    offer(1'b0, 4, 1'b1);
    tick();
    tick();
    tick();
    chk("t2_get2", 32'(bus.out_ep_data_get), 1);
    bus.out_ep_grant = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t2_no_get", 32'(bus.out_ep_data_get), 0);
      chk("t2_req_held", 32'(bus.out_ep_req), 1);
      tick();
    end
    bus.out_ep_grant = 1'b1;
    wait_done("t2", 20, 1'b0, k);
    repeat (3) tick();
    chk("t2_done_once", 32'(done_cnt - d0), 1);
    chk("t2_gets", 32'(get_cnt - g0), 4);
    chk("t2_bad_get", 32'(bad_get), 0);
    end_pkt("t2");
    repeat (4) pop_chk("t2_pop");

    // 100 bytes held, 64-byte OUT must wait for space
    offer(1'b0, 64, 1'b1); wait_done("t3a", 100, 1'b0, k); end_pkt("t3a");
    offer(1'b0, 36, 1'b1); wait_done("t3b", 100, 1'b0, k); end_pkt("t3b");
    chk("t3_level100", 32'(bus.app_level), 100);
    g0 = get_cnt;
    offer(1'b0, 64, 1'b1);
    repeat (10) tick();
    chk("t3_req_stall", 32'(bus.out_ep_req), 1);
    chk("t3_no_gets", 32'(get_cnt - g0), 0);
    repeat (35) pop_chk("t3_pop");
    chk("t3_still_stalled", 32'(get_cnt - g0), 0);
    pop_chk("t3_pop36");
    wait_done("t3c", 100, 1'b0, k);
    chk("t3_gets", 32'(get_cnt - g0), 64);
    chk("t3_level128", 32'(bus.app_level), 128);
    end_pkt("t3c");

    // SETUP while 20 bytes held: flush
    repeat (108) pop_chk("t4_pre");
    chk("t4_level20", 32'(bus.app_level), 20);
    offer(1'b1, 8, 1'b1);
    wait_done("t4", 40, 1'b0, k);
    chk("t4_level8", 32'(bus.app_level), 8);
    end_pkt("t4");
    repeat (8) pop_chk("t4_pop");
    chk("t4_empty", 32'(bus.app_empty), 1);

    // Zero-length OUT
    offer(1'b0, 5, 1'b1); wait_done("t5a", 40, 1'b0, k); end_pkt("t5a");
    g0 = get_cnt; d0 = done_cnt; z0 = zlp_cnt;
    offer(1'b0, 0, 1'b0);
    wait_done("t5", 20, 1'b0, k);
    repeat (3) tick();
    chk("t5_gets", 32'(get_cnt - g0), 0);
    chk("t5_zlp", 32'(zlp_cnt - z0), 1);
    chk("t5_done", 32'(done_cnt - d0), 1);
    chk("t5_level", 32'(bus.app_level), 5);
    end_pkt("t5");

    // Reset during the 3rd byte of a 10-byte packet
    g0 = get_cnt;
    offer(1'b0, 10, 1'b1);
    k = -1;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (get_cnt - g0 >= 3) begin
        k = c;
        break;
      end
    end
    chk("t6_third_get", 32'(k >= 0), 1);
    reset = 1'b1;
    #1;
    chk_reset_outputs("t6_rst");
    model.delete();
    model_push(1'b0, 10);
    tick();
    tick();
    reset = 1'b0;
    g0 = get_cnt;
    wait_done("t6", 40, 1'b0, k);
    chk("t6_gets", 32'(get_cnt - g0), 10);
    end_pkt("t6");
    chk("t6_level", 32'(bus.app_level), 10);
    repeat (10) pop_chk("t6_pop");

    // Randomized packets with random grant gaps and partial drains
    for (int p = 0; p < 12; p++) begin
      s   = ($urandom_range(0, 4) == 0);
      len = $urandom_range(0, 64);
      n = $urandom_range(0, model.size());
      repeat (n) pop_chk("rnd_pop");
      if (!s) while (model.size() + len > DEPTH) pop_chk("rnd_room");
      offer(s, len, 1'b1);
      wait_done("rnd", 400, 1'b1, k);
      chk("rnd_level", 32'(bus.app_level), 32'(model.size()));
      end_pkt("rnd");
    end
    while (model.size() > 0) pop_chk("rnd_drain");
    chk("rnd_empty", 32'(bus.app_empty), 1);
    chk("rnd_bad_get", 32'(bad_get), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
